// File: rtl/div_unit.sv
// Multi-cycle RISC-V DIV/DIVU/REM/REMU unit, non-restoring, BITS_PER_CYCLE bits/cycle.
// Optional DIV_SKIP_LZ_EN: skip leading all-zero quotient groups of |dividend|.
module div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_dividend,
  input  logic [XLEN-1:0]  in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    FIXUP,
    HOLD
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             sgn_a;
  logic             sgn_b;
  logic [XLEN:0]    acc;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  dvs;
  logic [CW-1:0]    count;

  function automatic logic [2*XLEN:0] iterate(
    input logic [XLEN:0]   a_in,
    input logic [XLEN-1:0] q_in,
    input logic [XLEN:0]   m
  );
    logic [XLEN:0]   a;
    logic [XLEN-1:0] q;
    logic            neg;
    a = a_in;
    q = q_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      neg  = a[XLEN];
      a    = {a[XLEN-1:0], q[XLEN-1]};
      q    = {q[XLEN-2:0], 1'b0};
      a    = neg ? a + m : a - m;
      q[0] = ~a[XLEN];
    end
    return {a, q};
  endfunction

`ifdef DIV_SKIP_LZ_EN
  function automatic logic [CW-1:0] lz_groups(
    input logic [XLEN-1:0] v
  );
    logic [CW-1:0] k;
    logic          hit;
    k   = '0;
    hit = 1'b0;
    for (int g = N - 1; g >= 0; g--) begin
      if (!hit && v[g*BITS_PER_CYCLE +: BITS_PER_CYCLE] == '0)
        k = k + 1'b1;
      else
        hit = 1'b1;
    end
    return k;
  endfunction
`endif

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [CW-1:0]   count_init;
  logic [XLEN-1:0] q_init;

  assign is_signed = ~in_op[0];
  assign a_neg     = is_signed & in_dividend[XLEN-1];
  assign b_neg     = is_signed & in_divisor[XLEN-1];
  assign a_mag     = a_neg ? -in_dividend : in_dividend;
  assign b_mag     = b_neg ? -in_divisor : in_divisor;
  assign div_zero  = in_divisor == '0;
  assign ovf       = is_signed
                  && in_dividend == {1'b1, {(XLEN-1){1'b0}}}
                  && in_divisor == '1;

`ifdef DIV_SKIP_LZ_EN
  logic [CW-1:0] skip;
  assign skip = lz_groups(a_mag);
  assign count_init = (skip >= CW'(N)) ? CW'(1)
                    : CW'(N) - skip;
  // a zero dividend shifts Q out entirely; one step on zeros is harmless
  assign q_init = a_mag << (skip * BITS_PER_CYCLE);
`else
  assign count_init = CW'(N);
  assign q_init     = a_mag;
`endif

  logic [XLEN:0]   acc_nx;
  logic [XLEN-1:0] quo_nx;

  assign {acc_nx, quo_nx} = iterate(acc, quo, {1'b0, dvs});

  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] sel_val;
  logic            sel_neg;
  logic [XLEN-1:0] res;

  // final remainder always fits XLEN bits, so the wrap is exact
  assign rem     = acc[XLEN-1:0] + (acc[XLEN] ? dvs : '0);
  assign sel_val = op_q[1] ? rem : quo;
  assign sel_neg = op_q[1] ? sgn_a : (sgn_a ^ sgn_b);
  assign res     = (sel_neg && sel_val != '0) ? -sel_val : sel_val;

  assign in_ready = (state == IDLE) && !flush;
  assign busy     = state != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      tag_q      <= '0;
      sgn_a      <= 1'b0;
      sgn_b      <= 1'b0;
      acc        <= '0;
      quo        <= '0;
      dvs        <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q  <= in_op;
            tag_q <= in_tag;
            sgn_a <= a_neg;
            sgn_b <= b_neg;
            acc   <= '0;
            dvs   <= b_mag;
            quo   <= q_init;
            count <= count_init;
            if (div_zero) begin
              out_result <= in_op[1] ? in_dividend : '1;
              out_tag    <= in_tag;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else if (ovf) begin
              out_result <= in_op[1] ? '0 : in_dividend;
              out_tag    <= in_tag;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else begin
              state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc   <= acc_nx;
          quo   <= quo_nx;
          count <= count - 1'b1;
          if (count == CW'(1))
            state <= FIXUP;
        end
        FIXUP: begin
          out_result <= res;
          out_tag    <= tag_q;
          out_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: BPC=1 and BPC=4 instances.
// Latency expectations follow DIV_SKIP_LZ_EN when defined.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  in_op = '0;
  logic [31:0] in_dividend = '0;
  logic [31:0] in_divisor = '0;
  logic [4:0]  in_tag = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        iv1 = 1'b0;
  logic        iv4 = 1'b0;
  logic        sel4 = 1'b0;

  logic        ir1, ov1, bz1;
  logic [31:0] res1;
  logic [4:0]  tag1;
  logic        ir4, ov4, bz4;
  logic [31:0] res4;
  logic [4:0]  tag4;

  logic        ir, ov, bz;
  logic [31:0] res;
  logic [4:0]  tg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(iv1), .in_ready(ir1), .in_op(in_op),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_tag(in_tag), .flush(flush),
    .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_tag(tag1), .busy(bz1)
  );

  div_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .TAG_W(5)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(iv4), .in_ready(ir4), .in_op(in_op),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .in_tag(in_tag), .flush(flush),
    .out_valid(ov4), .out_ready(out_ready),
    .out_result(res4), .out_tag(tag4), .busy(bz4)
  );

  assign ir  = sel4 ? ir4 : ir1;
  assign ov  = sel4 ? ov4 : ov1;
  assign bz  = sel4 ? bz4 : bz1;
  assign res = sel4 ? res4 : res1;
  assign tg  = sel4 ? tag4 : tag1;

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int bpc, input logic [31:0] mag);
    int n;
    int c;
    n = 32 / bpc;
    c = n;
`ifdef DIV_SKIP_LZ_EN
    begin
      int  k;
      bit  hit;
      k   = 0;
      hit = 0;
      for (int g = n - 1; g >= 0; g--) begin
        if (!hit && ((mag >> (g * bpc)) & ((32'd1 << bpc) - 1)) == 0)
          k++;
        else
          hit = 1;
      end
      c = n - k;
      if (c < 1) c = 1;
    end
`endif
    return c + 2;
  endfunction

  task automatic issue(input bit which, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input string name);
    @(negedge clk);
    check({name, "_in_ready"}, 32'(ir), 32'd1);
    in_op       = op;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = t;
    if (which) iv4 = 1'b1;
    else       iv1 = 1'b1;
    @(posedge clk);
    #1;
    iv1 = 1'b0;
    iv4 = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int lat_exp,
                            input logic [31:0] r_exp,
                            input logic [4:0] t_exp);
    int lat;
    lat = 1;
    @(negedge clk);
    while (!ov && lat < 120) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(lat_exp));
    check({name, "_result"}, res, r_exp);
    check({name, "_tag"}, 32'(tg), 32'(t_exp));
    check({name, "_busy"}, 32'(bz), 32'd1);
  endtask

  task automatic handshake(input string name);
    check({name, "_valid_at_hs"}, 32'(ov), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(ov), 32'd0);
    check({name, "_ready_after"}, 32'(ir), 32'd1);
  endtask

  initial begin
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_out_result", res1, 32'd0);
    check("rst_out_tag", 32'(tag1), 32'd0);
    check("rst_busy", 32'(bz1), 32'd0);
    check("rst4_out_valid", 32'(ov4), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(ir1), 32'd1);

    issue(0, 2'b00, 32'hFFFFFFF9, 32'd2, 5'h0A, "div_m7_2");
    wait_valid("div_m7_2", exp_lat(1, 32'd7), 32'hFFFFFFFD, 5'h0A);
    handshake("div_m7_2");

    issue(0, 2'b10, 32'hFFFFFFF9, 32'd2, 5'h15, "rem_m7_2");
    wait_valid("rem_m7_2", exp_lat(1, 32'd7), 32'hFFFFFFFF, 5'h15);
    handshake("rem_m7_2");

    issue(0, 2'b00, 32'd20, 32'hFFFFFFFD, 5'h03, "div_20_m3");
    wait_valid("div_20_m3", exp_lat(1, 32'd20), 32'hFFFFFFFA, 5'h03);
    handshake("div_20_m3");

    issue(0, 2'b10, 32'd20, 32'hFFFFFFFD, 5'h04, "rem_20_m3");
    wait_valid("rem_20_m3", exp_lat(1, 32'd20), 32'd2, 5'h04);
    handshake("rem_20_m3");

    issue(0, 2'b01, 32'hFFFFFFFF, 32'd16, 5'h1F, "divu_big");
    wait_valid("divu_big", exp_lat(1, 32'hFFFFFFFF), 32'h0FFFFFFF, 5'h1F);
    handshake("divu_big");

    issue(0, 2'b01, 32'd100, 32'd0, 5'h11, "divu_by0");
    wait_valid("divu_by0", 1, 32'hFFFFFFFF, 5'h11);
    handshake("divu_by0");

    issue(0, 2'b11, 32'd100, 32'd0, 5'h12, "remu_by0");
    wait_valid("remu_by0", 1, 32'h64, 5'h12);
    handshake("remu_by0");

    issue(0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 5'h13, "div_ovf");
    wait_valid("div_ovf", 1, 32'h80000000, 5'h13);
    handshake("div_ovf");

    issue(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'h14, "rem_ovf");
    wait_valid("rem_ovf", 1, 32'd0, 5'h14);
    handshake("rem_ovf");

    issue(0, 2'b01, 32'd1000, 32'd3, 5'h07, "bp");
    wait_valid("bp", exp_lat(1, 32'd1000), 32'd333, 5'h07);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_result", res, 32'd333);
      check("bp_hold_tag", 32'(tg), 32'h07);
      check("bp_hold_in_ready", 32'(ir), 32'd0);
      check("bp_hold_valid", 32'(ov), 32'd1);
    end
    handshake("bp");

    issue(0, 2'b00, 32'd50, 32'd5, 5'h09, "flush");
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    check("flush_in_ready_low", 32'(ir), 32'd0);
    check("flush_busy_before", 32'(bz), 32'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready_after", 32'(ir), 32'd1);
    check("flush_busy_after", 32'(bz), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ov) seen = 1'b1;
    end
    check("flush_no_result", 32'(seen), 32'd0);

    issue(0, 2'b01, 32'd9, 32'd4, 5'h0C, "divu_9_4");
    wait_valid("divu_9_4", exp_lat(1, 32'd9), 32'd2, 5'h0C);
    handshake("divu_9_4");

    sel4 = 1'b1;
    issue(1, 2'b11, 32'hFFFFFFFF, 32'd7, 5'h1A, "b4_remu");
    wait_valid("b4_remu", exp_lat(4, 32'hFFFFFFFF), 32'd3, 5'h1A);
    handshake("b4_remu");

    issue(1, 2'b01, 32'd5, 32'd1, 5'h1B, "b4_divu_5_1");
    wait_valid("b4_divu_5_1", exp_lat(4, 32'd5), 32'd5, 5'h1B);
    handshake("b4_divu_5_1");

    issue(1, 2'b00, 32'hFFFFFF9C, 32'd7, 5'h1C, "b4_div_m100_7");
    wait_valid("b4_div_m100_7", exp_lat(4, 32'd100), 32'hFFFFFFF2, 5'h1C);
    handshake("b4_div_m100_7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
